writeback_arbiter: RTL and testbench
====================================

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 SHALL have the port clk, input, 1 bit: rising-edge clock.
REQ-002 SHALL have the port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have, for each unit U in {alu1, alu2, advint, memunit, branch}, the port U_done, input, 1 bit: result valid, held until acked.
REQ-004 SHALL have, for each U, the port U_rd, input, 6 bits: destination register number.
REQ-005 SHALL have, for each U, the port U_data, input, 64 bits: result value.
REQ-006 SHALL have the port advint_rd2, input, 6 bits: second destination register number.
REQ-007 SHALL have the port advint_data2, input, 64 bits: second result value.
REQ-008 SHALL have, for each U, the port U_ack, output, 1 bit: combinational; result consumed this cycle.
REQ-009 SHALL have the ports wr1_en and wr2_en, output, 1 bit each: register-file write strobes.
REQ-010 SHALL have the ports wr1_rn and wr2_rn, output, 6 bits each: write register numbers.
REQ-011 SHALL have the ports wr1_data and wr2_data, output, 64 bits each: write values.
REQ-012 SHALL have the ports reg1_finished and reg2_finished, output, 6 bits each: retired register numbers, sent to the scheduler.

Function
REQ-013 SHALL grant at most two results per cycle, one per write port; unit order is alu1, alu2, advint, memunit, branch (indices 0-4).
REQ-014 SHALL give the first requesting unit at or after rr_ptr port 1, and the next requesting unit port 2.
REQ-015 SHALL assert U_ack in the same cycle that U is granted; a unit with U_done=0 SHALL never be acked.
REQ-016 SHALL grant an advint result atomically: both of its results take both ports in the same cycle, and only when advint is the first winner.
- If advint would be the second winner, it is skipped that cycle and the next requester takes port 2.
REQ-017 SHALL register write outputs one cycle after ack: wrN_en=1, wrN_rn=rd, wrN_data=data.
REQ-018 SHALL drive regN_finished equal to wrN_rn while wrN_en=1, and 0 otherwise.
REQ-019 SHALL ack a result with rd=0 normally but SHALL NOT write it: wrN_en=0, regN_finished=0. The same applies to advint_rd2=0.
REQ-020 SHALL, when both grants target the same nonzero rd, grant port 1 only; the port-2 candidate waits.
REQ-021 SHALL, after any grant, advance rr_ptr to one past the highest-order granted unit, modulo 5; with no grant, rr_ptr SHALL hold.
REQ-022 SHALL bound starvation: a unit holding done SHALL be acked within 5 cycles.

Reset
REQ-023 SHALL, on rst_n low, immediately clear all wrN_en, wrN_rn, wrN_data and regN_finished, and set rr_ptr=0.
REQ-024 SHALL force all U_ack to 0 while rst_n is low.
REQ-025 SHALL drop results pending at reset assertion; units are reset concurrently.
REQ-026 SHALL produce no write in the first cycle after reset release.

Configuration
REQ-027 SHALL, with WB_ROUND_ROBIN_EN defined, arbitrate per REQ-014/REQ-021.
REQ-028 SHALL, without WB_ROUND_ROBIN_EN, use fixed priority (index 0 highest) with rr_ptr held at 0; REQ-022 is then waived.

Structure
REQ-029 SHALL take REG_W=6, DATA_W=64, NUM_UNITS=5 and the unit-index constants from the shared package raisin64_pkg.
REQ-030 SHALL instantiate the sub-module rr_pick (N-way round-robin first-set finder, parameterised on N) twice: once for port 1, then once with the port-1 winner masked.

Verification
REQ-031 SHALL check: alu1_done=1 (rd=5, data=0xAA) alone -> alu1_ack same cycle; next cycle wr1_en=1, wr1_rn=5, reg1_finished=5, wr2_en=0.
REQ-032 SHALL check: alu1, alu2, memunit all done with rr_ptr=0 -> alu1 on port 1, alu2 on port 2; memunit acked the following cycle; rr_ptr becomes 2, then 4.
REQ-033 SHALL check: advint done (rd=7, rd2=8) with alu1 also done, rr_ptr=0 -> only alu1 granted; advint granted next cycle with wr1_rn=7, wr2_rn=8.
REQ-034 SHALL check: branch done with rd=0 -> branch_ack=1; next cycle wr1_en=0, reg1_finished=0.
REQ-035 SHALL check: all five units held done for 10 cycles -> each acked within 5 cycles; with WB_ROUND_ROBIN_EN undefined, branch is never acked while alu1 and alu2 stay done.
REQ-036 SHALL check: rst_n asserted mid-grant -> outputs 0 immediately; after release, alu2-only done -> port 1, rr_ptr=2.

Source files
------------

// File: rtl/raisin64_pkg.sv
// raisin64_pkg: shared widths, unit indices and write-port record for the writeback path
package raisin64_pkg;
  localparam int REG_W = 6;
  localparam int DATA_W = 64;
  localparam int NUM_UNITS = 5;
  localparam int U_ALU1 = 0;
  localparam int U_ALU2 = 1;
  localparam int U_ADVINT = 2;
  localparam int U_MEMUNIT = 3;
  localparam int U_BRANCH = 4;
  typedef logic [$clog2(NUM_UNITS)-1:0] unit_idx_t;
  typedef struct packed {
    logic en;
    logic [REG_W-1:0] rn;
    logic [DATA_W-1:0] data;
  } wr_port_t;
  function automatic unit_idx_t next_unit(unit_idx_t i);
    return (i == unit_idx_t'(NUM_UNITS - 1)) ? '0 : i + 1'b1;
  endfunction
endpackage

// File: rtl/writeback_arbiter_rr_pick.sv
// rr_pick: finds the first set request at or after ptr, wrapping around N entries
module rr_pick #(
  parameter int N = 5,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx,
  output logic [N-1:0]  onehot
);
  logic [IW-1:0] c;
  always_comb begin
    found = 1'b0;
    idx = '0;
    c = '0;
    for (int k = N - 1; k >= 0; k--) begin
      c = IW'((int'(ptr) + k) % N);
      if (req[c]) begin
        found = 1'b1;
        idx = c;
      end
    end
    onehot = found ? (N'(1) << idx) : '0;
  end
endmodule

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: grants up to two unit results per cycle onto two register-file write ports.
// Define WB_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority (alu1 highest).
module writeback_arbiter
  import raisin64_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu1_done,
  input  logic [REG_W-1:0]  alu1_rd,
  input  logic [DATA_W-1:0] alu1_data,
  input  logic              alu2_done,
  input  logic [REG_W-1:0]  alu2_rd,
  input  logic [DATA_W-1:0] alu2_data,
  input  logic              advint_done,
  input  logic [REG_W-1:0]  advint_rd,
  input  logic [DATA_W-1:0] advint_data,
  input  logic [REG_W-1:0]  advint_rd2,
  input  logic [DATA_W-1:0] advint_data2,
  input  logic              memunit_done,
  input  logic [REG_W-1:0]  memunit_rd,
  input  logic [DATA_W-1:0] memunit_data,
  input  logic              branch_done,
  input  logic [REG_W-1:0]  branch_rd,
  input  logic [DATA_W-1:0] branch_data,
  output logic              alu1_ack,
  output logic              alu2_ack,
  output logic              advint_ack,
  output logic              memunit_ack,
  output logic              branch_ack,
  output logic              wr1_en,
  output logic [REG_W-1:0]  wr1_rn,
  output logic [DATA_W-1:0] wr1_data,
  output logic              wr2_en,
  output logic [REG_W-1:0]  wr2_rn,
  output logic [DATA_W-1:0] wr2_data,
  output logic [REG_W-1:0]  reg1_finished,
  output logic [REG_W-1:0]  reg2_finished
);
  logic [NUM_UNITS-1:0] req, oh1, oh2, mask2, grant;
  logic [REG_W-1:0] rd_a [NUM_UNITS];
  logic [DATA_W-1:0] data_a [NUM_UNITS];
  unit_idx_t rr_ptr_q, rr_ptr_d, i1, i2;
  logic f1, f2, adv_first, conflict, g2;
  wr_port_t wr1_d, wr1_q, wr2_d, wr2_q;
  assign req = {branch_done, memunit_done, advint_done, alu2_done, alu1_done};
  assign rd_a = '{alu1_rd, alu2_rd, advint_rd, memunit_rd, branch_rd};
  assign data_a = '{alu1_data, alu2_data, advint_data, memunit_data, branch_data};
  // advint never competes for port 2: it only goes out as the first winner, using both ports
  assign mask2 = req & ~oh1 & ~(NUM_UNITS'(1) << U_ADVINT);
  rr_pick #(.N(NUM_UNITS)) u_pick1 (.req(req), .ptr(rr_ptr_q), .found(f1), .idx(i1), .onehot(oh1));
  rr_pick #(.N(NUM_UNITS)) u_pick2 (.req(mask2), .ptr(rr_ptr_q), .found(f2), .idx(i2), .onehot(oh2));
  always_comb begin
    adv_first = f1 && (i1 == unit_idx_t'(U_ADVINT));
    conflict = (rd_a[i2] == rd_a[i1]) && (rd_a[i1] != '0);
    g2 = f2 && !adv_first && !conflict;
    grant = oh1 | (g2 ? oh2 : '0);
    wr1_d = wr_port_t'{en: f1 && (rd_a[i1] != '0), rn: rd_a[i1], data: data_a[i1]};
    wr2_d = adv_first ? wr_port_t'{en: advint_rd2 != '0, rn: advint_rd2, data: advint_data2}
                      : wr_port_t'{en: g2 && (rd_a[i2] != '0), rn: rd_a[i2], data: data_a[i2]};
`ifdef WB_ROUND_ROBIN_EN
    rr_ptr_d = f1 ? next_unit(g2 ? i2 : i1) : rr_ptr_q;
`else
    rr_ptr_d = '0;
`endif
  end
  assign {branch_ack, memunit_ack, advint_ack, alu2_ack, alu1_ack} = rst_n ? grant : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr1_q <= '0;
      wr2_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      wr1_q <= wr1_d;
      wr2_q <= wr2_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end
  assign wr1_en = wr1_q.en;
  assign wr1_rn = wr1_q.rn;
  assign wr1_data = wr1_q.data;
  assign wr2_en = wr2_q.en;
  assign wr2_rn = wr2_q.rn;
  assign wr2_data = wr2_q.data;
  assign reg1_finished = wr1_q.en ? wr1_q.rn : '0;
  assign reg2_finished = wr2_q.en ? wr2_q.rn : '0;
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: scoreboard bench for writeback_arbiter in either arbitration build
module tb_writeback_arbiter;
  typedef struct packed {
    logic e1;
    logic [5:0] r1;
    logic [63:0] d1;
    logic e2;
    logic [5:0] r2;
    logic [63:0] d2;
  } wexp_t;
`ifdef WB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk, rst_n;
  logic [4:0] done;
  logic [5:0] rd [5];
  logic [63:0] dat [5];
  logic [5:0] advint_rd2;
  logic [63:0] advint_data2;
  wire [4:0] ack;
  wire wr1_en, wr2_en;
  wire [5:0] wr1_rn, wr2_rn, reg1_finished, reg2_finished;
  wire [63:0] wr1_data, wr2_data;
  wexp_t sb[$];
  int checks = 0;
  int errors = 0;

  writeback_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .alu1_done(done[0]), .alu1_rd(rd[0]), .alu1_data(dat[0]),
    .alu2_done(done[1]), .alu2_rd(rd[1]), .alu2_data(dat[1]),
    .advint_done(done[2]), .advint_rd(rd[2]), .advint_data(dat[2]),
    .advint_rd2(advint_rd2), .advint_data2(advint_data2),
    .memunit_done(done[3]), .memunit_rd(rd[3]), .memunit_data(dat[3]),
    .branch_done(done[4]), .branch_rd(rd[4]), .branch_data(dat[4]),
    .alu1_ack(ack[0]), .alu2_ack(ack[1]), .advint_ack(ack[2]),
    .memunit_ack(ack[3]), .branch_ack(ack[4]),
    .wr1_en(wr1_en), .wr1_rn(wr1_rn), .wr1_data(wr1_data),
    .wr2_en(wr2_en), .wr2_rn(wr2_rn), .wr2_data(wr2_data),
    .reg1_finished(reg1_finished), .reg2_finished(reg2_finished)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic wexp_t wx(logic e1, logic [5:0] r1, logic [63:0] d1,
                               logic e2, logic [5:0] r2, logic [63:0] d2);
    return '{e1: e1, r1: r1, d1: d1, e2: e2, r2: r2, d2: d2};
  endfunction

  task automatic setu(input int u, input logic [5:0] r, input logic [63:0] d);
    done[u] = 1'b1;
    rd[u] = r;
    dat[u] = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    done = '0;
    advint_rd2 = '0;
    advint_data2 = '0;
    for (int i = 0; i < 5; i++) begin
      rd[i] = '0;
      dat[i] = '0;
    end
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // One arbitration cycle: acks checked now, expected writes queued and compared after the edge
  task automatic cyc(input logic [4:0] eack, input wexp_t w);
    wexp_t x;
    #1;
    checks++;
    if (ack !== eack) begin
      errors++;
      $display("FAIL ack: got %b want %b at %0t", ack, eack, $time);
    end
    sb.push_back(w);
    @(posedge clk);
    #1;
    done = done & ~eack;
    x = sb.pop_front();
    checks++;
    if (wr1_en !== x.e1) begin
      errors++;
      $display("FAIL wr1_en: got %b want %b at %0t", wr1_en, x.e1, $time);
    end
    if (x.e1) begin
      checks++;
      if (wr1_rn !== x.r1 || wr1_data !== x.d1) begin
        errors++;
        $display("FAIL wr1: got rn=%0d data=%h want rn=%0d data=%h", wr1_rn, wr1_data, x.r1, x.d1);
      end
    end
    checks++;
    if (reg1_finished !== (x.e1 ? x.r1 : 6'd0)) begin
      errors++;
      $display("FAIL reg1_finished: got %0d want %0d", reg1_finished, x.e1 ? x.r1 : 6'd0);
    end
    checks++;
    if (wr2_en !== x.e2) begin
      errors++;
      $display("FAIL wr2_en: got %b want %b at %0t", wr2_en, x.e2, $time);
    end
    if (x.e2) begin
      checks++;
      if (wr2_rn !== x.r2 || wr2_data !== x.d2) begin
        errors++;
        $display("FAIL wr2: got rn=%0d data=%h want rn=%0d data=%h", wr2_rn, wr2_data, x.r2, x.d2);
      end
    end
    checks++;
    if (reg2_finished !== (x.e2 ? x.r2 : 6'd0)) begin
      errors++;
      $display("FAIL reg2_finished: got %0d want %0d", reg2_finished, x.e2 ? x.r2 : 6'd0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    done = 5'b11111;
    for (int i = 0; i < 5; i++) begin
      rd[i] = 6'(i + 1);
      dat[i] = 64'(i);
    end
    #1;
    checks++;
    if (ack !== 5'b0 || wr1_en !== 1'b0 || wr2_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: ack=%b wr1_en=%b wr2_en=%b want 0", ack, wr1_en, wr2_en);
    end
    @(posedge clk);
    #1;
    checks++;
    if (ack !== 5'b0 || wr1_en !== 1'b0 || reg1_finished !== 6'd0 || reg2_finished !== 6'd0) begin
      errors++;
      $display("FAIL reset_edge: ack=%b wr1_en=%b fin=%0d/%0d want 0", ack, wr1_en, reg1_finished, reg2_finished);
    end
    checks++;
    if (dut.rr_ptr_q !== 3'd0) begin
      errors++;
      $display("FAIL reset_ptr: got %0d want 0", dut.rr_ptr_q);
    end
    done = '0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (wr1_en !== 1'b0 || wr2_en !== 1'b0) begin
      errors++;
      $display("FAIL post_release: wr1_en=%b wr2_en=%b want 0", wr1_en, wr2_en);
    end
  endtask

  task automatic test_single();
    do_reset();
    setu(0, 6'd5, 64'hAA);
    cyc(5'b00001, wx(1, 6'd5, 64'hAA, 0, 0, 0));
  endtask

  task automatic test_three();
    do_reset();
    setu(0, 6'd1, 64'h11);
    setu(1, 6'd2, 64'h22);
    setu(3, 6'd3, 64'h33);
    cyc(5'b00011, wx(1, 6'd1, 64'h11, 1, 6'd2, 64'h22));
    checks++;
    if (dut.rr_ptr_q !== (RR ? 3'd2 : 3'd0)) begin
      errors++;
      $display("FAIL three_ptr1: got %0d want %0d", dut.rr_ptr_q, RR ? 3'd2 : 3'd0);
    end
    cyc(5'b01000, wx(1, 6'd3, 64'h33, 0, 0, 0));
    checks++;
    if (dut.rr_ptr_q !== (RR ? 3'd4 : 3'd0)) begin
      errors++;
      $display("FAIL three_ptr2: got %0d want %0d", dut.rr_ptr_q, RR ? 3'd4 : 3'd0);
    end
  endtask

  task automatic test_advint();
    do_reset();
    setu(0, 6'd9, 64'h99);
    setu(2, 6'd7, 64'h77);
    advint_rd2 = 6'd8;
    advint_data2 = 64'h88;
    cyc(5'b00001, wx(1, 6'd9, 64'h99, 0, 0, 0));
    cyc(5'b00100, wx(1, 6'd7, 64'h77, 1, 6'd8, 64'h88));
    do_reset();
    setu(0, 6'd9, 64'h99);
    setu(2, 6'd7, 64'h77);
    setu(3, 6'd10, 64'hA0);
    advint_rd2 = 6'd8;
    advint_data2 = 64'h88;
    cyc(5'b01001, wx(1, 6'd9, 64'h99, 1, 6'd10, 64'hA0));
    cyc(5'b00100, wx(1, 6'd7, 64'h77, 1, 6'd8, 64'h88));
  endtask

  task automatic test_rd_zero();
    do_reset();
    setu(4, 6'd0, 64'h55);
    cyc(5'b10000, wx(0, 0, 0, 0, 0, 0));
    setu(0, 6'd12, 64'hC1);
    setu(1, 6'd12, 64'hC2);
    cyc(5'b00001, wx(1, 6'd12, 64'hC1, 0, 0, 0));
    cyc(5'b00010, wx(1, 6'd12, 64'hC2, 0, 0, 0));
    setu(2, 6'd4, 64'h44);
    advint_rd2 = 6'd0;
    advint_data2 = 64'h45;
    cyc(5'b00100, wx(1, 6'd4, 64'h44, 0, 0, 0));
  endtask

  task automatic test_starve();
    int last [5];
    int maxgap [5];
    do_reset();
    for (int i = 0; i < 5; i++) begin
      setu(i, 6'(i + 1), 64'(16 * i));
      last[i] = -1;
      maxgap[i] = 0;
    end
    for (int c = 0; c < 10; c++) begin
      #1;
      for (int u = 0; u < 5; u++) begin
        if (ack[u]) begin
          if (c - last[u] > maxgap[u]) maxgap[u] = c - last[u];
          last[u] = c;
        end
      end
`ifndef WB_ROUND_ROBIN_EN
      checks++;
      if (ack !== 5'b00011) begin
        errors++;
        $display("FAIL fixed_prio cycle %0d: got %b want 00011", c, ack);
      end
`endif
      @(posedge clk);
      #1;
    end
`ifdef WB_ROUND_ROBIN_EN
    for (int u = 0; u < 5; u++) begin
      if (10 - last[u] > maxgap[u]) maxgap[u] = 10 - last[u];
      checks++;
      if (maxgap[u] > 5) begin
        errors++;
        $display("FAIL starve unit %0d: gap %0d cycles want <= 5", u, maxgap[u]);
      end
    end
`endif
    done = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    setu(0, 6'd20, 64'h2020);
    cyc(5'b00001, wx(1, 6'd20, 64'h2020, 0, 0, 0));
    setu(1, 6'd21, 64'h2121);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (wr1_en !== 1'b0 || wr1_rn !== 6'd0 || wr1_data !== 64'd0 || reg1_finished !== 6'd0 || ack !== 5'b0) begin
      errors++;
      $display("FAIL mid_reset: wr1_en=%b rn=%0d data=%h fin=%0d ack=%b want 0",
               wr1_en, wr1_rn, wr1_data, reg1_finished, ack);
    end
    done = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    setu(1, 6'd22, 64'h2222);
    cyc(5'b00010, wx(1, 6'd22, 64'h2222, 0, 0, 0));
    checks++;
    if (dut.rr_ptr_q !== (RR ? 3'd2 : 3'd0)) begin
      errors++;
      $display("FAIL mid_reset_ptr: got %0d want %0d", dut.rr_ptr_q, RR ? 3'd2 : 3'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    done = '0;
    advint_rd2 = '0;
    advint_data2 = '0;
    for (int i = 0; i < 5; i++) begin
      rd[i] = '0;
      dat[i] = '0;
    end
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_three();
    test_advint();
    test_rd_zero();
    test_starve();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
